// File: rtl/mosi_cmd_sequencer_if.sv
// Command stream from the sequencer to the SPI engine: one half-word per
// valid/ready handshake.
interface mosi_cmd_sequencer_if #(
  parameter int unsigned DATA_W = 16
);
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_valid;
  logic              cmd_ready;

  modport master (
    output cmd_data,
    output cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready
  );
endinterface

// File: rtl/mosi_cmd_sequencer.sv
// Walks a command-RAM address range (optionally looping) and streams each
// stored half-word to the SPI engine, hiding the RAM's one-cycle read latency.
module mosi_cmd_sequencer #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_W-1:0]     addr_start,
  input  logic [ADDR_W-1:0]     addr_end,
  input  logic                  loop_en,
  input  logic [ADDR_W-1:0]     loop_addr,
  output logic [ADDR_W-1:0]     RAM_addr_B,
  input  logic [DATA_W-1:0]     RAM_data_out_B,
  mosi_cmd_sequencer_if.master  cmd,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           word_count,
  output logic [15:0]           loop_count
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ1   = 3'd1,
    ST_READ2   = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   addr_end_q, addr_end_d;
  logic                loop_en_q, loop_en_d;
  logic [ADDR_W-1:0]   loop_addr_q, loop_addr_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   cmd_data_q, cmd_data_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    word_count_q, word_count_d;
  logic [CNT_W-1:0]    loop_count_q, loop_count_d;
  logic                stop_pend_q, stop_pend_d;
  logic                hs;

  assign hs = cmd_valid_q && cmd.cmd_ready;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      addr_end_q   <= '0;
      loop_en_q    <= 1'b0;
      loop_addr_q  <= '0;
      ram_addr_q   <= '0;
      cmd_data_q   <= '0;
      cmd_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      word_count_q <= '0;
      loop_count_q <= '0;
      stop_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      addr_end_q   <= addr_end_d;
      loop_en_q    <= loop_en_d;
      loop_addr_q  <= loop_addr_d;
      ram_addr_q   <= ram_addr_d;
      cmd_data_q   <= cmd_data_d;
      cmd_valid_q  <= cmd_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      word_count_q <= word_count_d;
      loop_count_q <= loop_count_d;
      stop_pend_q  <= stop_pend_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    addr_end_d   = addr_end_q;
    loop_en_d    = loop_en_q;
    loop_addr_d  = loop_addr_q;
    ram_addr_d   = ram_addr_q;
    cmd_data_d   = cmd_data_q;
    cmd_valid_d  = cmd_valid_q;
    word_count_d = word_count_q;
    loop_count_d = loop_count_q;
    stop_pend_d  = stop_pend_q;

    unique case (state_q)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          addr_end_d   = addr_end;
          loop_en_d    = loop_en;
          loop_addr_d  = loop_addr;
          addr_d       = addr_start;
          ram_addr_d   = addr_start;
          word_count_d = '0;
          loop_count_d = '0;
          state_d      = ST_READ1;
        end
      end
      ST_READ1: begin
        state_d = stop ? ST_DONE : ST_READ2;
      end
      ST_READ2: begin
        if (stop) begin
          state_d = ST_DONE;
        end else begin
          cmd_data_d  = RAM_data_out_B;
          cmd_valid_d = 1'b1;
          state_d     = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        stop_pend_d = stop_pend_q | stop;
        // An offered word stays up until taken; stop only ends things afterwards
        if (hs) begin
          cmd_valid_d  = 1'b0;
          word_count_d = word_count_q + CNT_W'(1);
          if (stop_pend_q || stop) begin
            state_d = ST_DONE;
          end else if (addr_q == addr_end_q) begin
            if (loop_en_q) begin
              addr_d       = loop_addr_q;
              loop_count_d = loop_count_q + CNT_W'(1);
              state_d      = ST_READ1;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_READ1;
          end
          ram_addr_d = addr_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign RAM_addr_B    = ram_addr_q;
  assign cmd.cmd_data  = cmd_data_q;
  assign cmd.cmd_valid = cmd_valid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign word_count    = word_count_q;
  assign loop_count    = loop_count_q;

endmodule
